// File: rtl/uart_bus_master.sv
// uart_bus_master: byte-command parser that issues single-word bus reads/writes and returns ack or read data bytes
module uart_bus_master #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int READ_WAIT      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [31:0] praddr,
    output logic [31:0] prwd,
    output logic        prwe,
    output logic [3:0]  prbe,
    input  logic [31:0] prrd,
    output logic        busy,
    output logic        err_overrun
);
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, REQ, WRITE, RD_WAIT, RESP} state_t;

    state_t      state, state_n;
    logic        is_rd;
    logic [1:0]  cnt;
    logic [31:0] addr_sr, data_sr, resp_sr;
    logic [2:0]  rlen;
    logic [GW-1:0] gap;
    logic [3:0]  wcnt;
    logic        is_cmd, timed_out, last_byte, wait_done;

    assign is_cmd    = rx_data == 8'h57 || rx_data == 8'h52;
    assign timed_out = !rx_valid && gap == GW'(TIMEOUT_CYCLES - 1);
    assign last_byte = rx_valid && cnt == 2'd3;
    assign wait_done = wcnt == 4'(READ_WAIT - 1);
    assign tx_valid  = state == RESP;
    assign tx_data   = resp_sr[31:24];
    assign bus_req   = state == REQ || state == WRITE || state == RD_WAIT;
    assign prwe      = state == WRITE;
    assign prbe      = 4'hF;
    assign busy      = state != IDLE;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next-state decode
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = rx_valid ? (is_cmd ? ADDR : RESP) : IDLE;
            ADDR:    state_n = timed_out ? IDLE : last_byte ? (is_rd ? REQ : DATA) : ADDR;
            DATA:    state_n = timed_out ? IDLE : last_byte ? REQ : DATA;
            REQ:     state_n = bus_gnt ? (is_rd ? RD_WAIT : WRITE) : REQ;
            WRITE:   state_n = RESP;
            RD_WAIT: state_n = wait_done ? RESP : RD_WAIT;
            RESP:    state_n = (tx_ready && rlen == 3'd1) ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    // frame assembly, bus drive, response shifting and overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_rd       <= 1'b0;
            cnt         <= 2'd0;
            addr_sr     <= '0;
            data_sr     <= '0;
            resp_sr     <= '0;
            rlen        <= 3'd0;
            gap         <= '0;
            wcnt        <= 4'd0;
            praddr      <= '0;
            prwd        <= '0;
            err_overrun <= 1'b0;
        end else begin
            if (rx_valid && (state == REQ || state == WRITE || state == RD_WAIT || state == RESP))
                err_overrun <= 1'b1;
            case (state)
                IDLE: begin
                    gap <= '0;
                    cnt <= 2'd0;
                    if (rx_valid) begin
                        is_rd <= rx_data == 8'h52;
                        if (!is_cmd) begin
                            resp_sr <= {8'h3F, 24'h0};
                            rlen    <= 3'd1;
                        end
                    end
                end
                ADDR, DATA: begin
                    gap <= rx_valid ? '0 : gap + 1'b1;
                    if (rx_valid) begin
                        cnt <= cnt + 2'd1;
                        if (state == ADDR) addr_sr <= {addr_sr[23:0], rx_data};
                        else               data_sr <= {data_sr[23:0], rx_data};
                    end
                end
                REQ: begin
                    wcnt <= 4'd0;
                    if (bus_gnt) begin
                        praddr <= {addr_sr[31:2], 2'b00};
                        if (!is_rd) prwd <= data_sr;
                    end
                end
                WRITE: begin
                    resp_sr <= {8'h4B, 24'h0};
                    rlen    <= 3'd1;
                end
                RD_WAIT: begin
                    if (wait_done) begin
                        resp_sr <= prrd;
                        rlen    <= 3'd4;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                RESP: begin
                    if (tx_ready) begin
                        resp_sr <= resp_sr << 8;
                        rlen    <= rlen - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Debug/loader bus initiator: parses a byte command stream from the UART receive path and issues single-word reads and writes on the CPU-side peripheral bus (praddr/prwd/prwe/prbe/prrd) that the bridge responds to.
- Returns acknowledge bytes or read-data bytes on a byte transmit interface.
- Sits beside the CPU as a second bus initiator; it gains the bus through a req/gnt handshake with the top-level arbiter.

Parameters:
- TIMEOUT_CYCLES, 50000, maximum idle clocks between bytes of one frame before the partial frame is discarded.
- READ_WAIT, 1, clocks between driving praddr and sampling prrd (1..15).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle pulse; rx_data valid this cycle; no backpressure
- tx_data  output  8  byte to transmit
- tx_valid  output  1  tx_data valid; held until accepted
- tx_ready  input  1  transmitter accepts tx_data when tx_valid&&tx_ready
- bus_req  output  1  request for bus ownership
- bus_gnt  input  1  bus granted; arbiter holds high while bus_req high
- praddr  output  32  bus address (word aligned; bits[1:0] forced 0)
- prwd  output  32  bus write data
- prwe  output  1  bus write strobe
- prbe  output  4  byte enables, 4'b1111 for every access
- prrd  input  32  bus read data
- busy  output  1  high in any state other than IDLE
- err_overrun  output  1  sticky; set when a byte is dropped

Behaviour:
- Reset (async, immediate): state IDLE, tx_valid=0, tx_data=0, bus_req=0, prwe=0, praddr=0, prwd=0, prbe=4'b1111, err_overrun=0, counters cleared. Reset mid-frame or mid-access abandons everything; no response byte is sent.
- Frame formats, multi-byte fields sent MSB first:
  - Write: 0x57 'W', A3..A0, D3..D0 -> response 0x4B 'K'.
  - Read: 0x52 'R', A3..A0 -> response four bytes, prrd[31:24] first.
  - Any other command byte -> response 0x3F '?', then IDLE.
- States:
  - IDLE: on rx_valid, decode the command. W/R go to ADDR (count 0); other bytes go to RESP with '?'.
  - ADDR: shift four bytes into the address. After the 4th byte: W goes to DATA, R goes to REQ.
  - DATA: shift four bytes into the data register. After the 4th byte, go to REQ.
  - REQ: bus_req=1. Wait for bus_gnt=1, then go to WRITE (W) or RD_WAIT (R). Stay in REQ indefinitely while gnt is low.
  - WRITE: praddr/prwd are driven. prwe=1 for exactly one cycle. Next state RESP with 'K'. bus_req drops in the same cycle as the move to RESP.
  - RD_WAIT: praddr is driven, prwe=0. Count READ_WAIT cycles, then capture prrd into the response shift register, drop bus_req, and go to RESP with 4 bytes.
  - RESP: tx_valid=1 with the current byte. On tx_valid&&tx_ready, advance to the next byte; after the last byte is accepted, go to IDLE.
- Bus outputs hold their last value outside WRITE/RD_WAIT. prwe is 0 in every state except WRITE.
- Timeout: in ADDR/DATA, a gap counter resets on each rx_valid. If it reaches TIMEOUT_CYCLES, go to IDLE silently with no response.
- rx_valid in REQ/WRITE/RD_WAIT/RESP: the byte is dropped and err_overrun=1. Only rst clears err_overrun.
- Address bits [1:0] received are ignored; praddr[1:0]=0.
- A rx_valid in the same cycle that RESP completes is dropped (the state is still RESP) and err_overrun is set.
- Latency, write frame: last data byte -> prwe pulse = 1 (REQ) + grant wait + 1 cycles. With gnt already high, prwe occurs 2 cycles after the last rx_valid.

Test Plan:
- Write: bytes 57 00 00 7F 04 12 34 56 78, gnt tied 1 -> one prwe pulse with praddr=0x00007F04, prwd=0x12345678, prbe=F; then tx 0x4B.
- Read: bytes 52 00 00 7F 10 with prrd=0xDEADBEEF, READ_WAIT=1 -> prwe stays 0; tx 0xDE,0xAD,0xBE,0xEF in order. Hold tx_ready low 5 cycles on byte 2 -> tx_data stays 0xAD.
- Grant stall: gnt low for 20 cycles after a write frame -> bus_req high, no prwe; prwe fires the 2nd cycle after gnt rises.
- Bad command: byte 0x41 -> tx 0x3F, busy returns 0; a following valid W frame then works.
- Timeout: send 57 00 00, then idle TIMEOUT_CYCLES (bench override 100) -> IDLE, no tx. Next 52 ... frame is decoded fresh.
- Overrun/reset: send a byte during RESP -> err_overrun=1. Assert rst during RD_WAIT -> all outputs return to reset values asynchronously and err_overrun=0.
